pdm_cic_decimator: RTL and testbench

Converts the 1-bit PDM stream from the MEMS microphone into signed 16-bit PCM samples using a 3rd-order CIC decimator. It sits directly downstream of the microphone capture stage. It samples `micData` on a one-cycle strobe generated from the microphone clock divider, decimates by 2^DEC_LOG2, and presents PCM words on a valid/ready handshake to the audio buffer or playback path.

---
 rtl/pdm_cic_decimator.sv | 195 +++++++++++++++++++
 tb/tb_pdm_cic_decimator.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pdm_cic_decimator.sv
// 1-bit PDM to signed PCM converter: 3rd-order CIC decimator (R = 2^DEC_LOG2) with a one-entry valid/ready output.
// Optional build macro PCM_DC_BLOCK_EN inserts a first-order DC-blocking high-pass filter before the output register.
module pdm_cic_decimator #(
  parameter int DEC_LOG2 = 6,
  parameter int OUT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pdm_tick,
  input  logic                    micData,
  output logic signed [OUT_W-1:0] pcm_data,
  output logic                    pcm_valid,
  input  logic                    pcm_ready,
  output logic                    overrun,
  input  logic                    clr_ovr
);

  localparam int ACC_W = 3 * DEC_LOG2 + 2;
  localparam int SHIFT = 3 * DEC_LOG2 + 1 - OUT_W;
  localparam int DC_W  = OUT_W + 2;

  localparam logic [DEC_LOG2-1:0]     CNT_MAX = {DEC_LOG2{1'b1}};
  localparam logic [DEC_LOG2-1:0]     CNT_ONE = {{(DEC_LOG2-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COMB1 = 3'd1,
    S_COMB2 = 3'd2,
    S_COMB3 = 3'd3,
    S_DCB   = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t                    r_state;
  logic [DEC_LOG2-1:0]       r_cnt;
  logic signed [ACC_W-1:0]   r_i1;
  logic signed [ACC_W-1:0]   r_i2;
  logic signed [ACC_W-1:0]   r_i3;
  logic signed [ACC_W-1:0]   r_i3_lat;
  logic signed [ACC_W-1:0]   r_i3_d;
  logic signed [ACC_W-1:0]   r_c1;
  logic signed [ACC_W-1:0]   r_c1_d;
  logic signed [ACC_W-1:0]   r_c2;
  logic signed [ACC_W-1:0]   r_c2_d;
  logic signed [ACC_W-1:0]   r_c3;

  logic signed [ACC_W-1:0]   w_x;
  logic signed [ACC_W-1:0]   w_i1_nx;
  logic signed [ACC_W-1:0]   w_i2_nx;
  logic signed [ACC_W-1:0]   w_i3_nx;
  logic                      w_dec_tick;
  logic signed [ACC_W-1:0]   w_sc_full;
  logic signed [OUT_W-1:0]   w_scaled;
  logic signed [OUT_W-1:0]   w_out_val;

  // PDM bit maps to +1 / -1; integrators wrap modulo 2^ACC_W by design.
  assign w_x        = micData ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};
  assign w_i1_nx    = r_i1 + w_x;
  assign w_i2_nx    = r_i2 + w_i1_nx;
  assign w_i3_nx    = r_i3 + w_i2_nx;
  assign w_dec_tick = pdm_tick && (r_cnt == CNT_MAX);
  assign w_sc_full  = r_c3 >>> SHIFT;

  // Only the full-scale positive value can exceed the signed output range.
  always_comb begin
    w_scaled = w_sc_full[OUT_W-1:0];
    if (w_sc_full > SAT_MAX) begin
      w_scaled = SAT_MAX[OUT_W-1:0];
    end else if (w_sc_full < SAT_MIN) begin
      w_scaled = SAT_MIN[OUT_W-1:0];
    end else begin
      w_scaled = w_sc_full[OUT_W-1:0];
    end
  end

`ifdef PCM_DC_BLOCK_EN
  localparam logic signed [DC_W-1:0] DC_MAX = {3'b000, {(OUT_W-1){1'b1}}};
  localparam logic signed [DC_W-1:0] DC_MIN = {3'b111, {(OUT_W-1){1'b0}}};

  logic signed [OUT_W-1:0] r_dc_s;
  logic signed [OUT_W-1:0] r_dc_h;
  logic signed [DC_W-1:0]  w_dc_sum;
  logic signed [DC_W-1:0]  w_dc_hx;
  logic signed [OUT_W-1:0] w_dc_sat;

  assign w_dc_hx  = {{2{r_dc_h[OUT_W-1]}}, r_dc_h};
  assign w_dc_sum = {{2{w_scaled[OUT_W-1]}}, w_scaled} - {{2{r_dc_s[OUT_W-1]}}, r_dc_s}
                  + w_dc_hx - (w_dc_hx >>> 8);
  assign w_out_val = r_dc_h;

  // Saturate the high-pass result back to the output width.
  always_comb begin
    w_dc_sat = w_dc_sum[OUT_W-1:0];
    if (w_dc_sum > DC_MAX) begin
      w_dc_sat = DC_MAX[OUT_W-1:0];
    end else if (w_dc_sum < DC_MIN) begin
      w_dc_sat = DC_MIN[OUT_W-1:0];
    end else begin
      w_dc_sat = w_dc_sum[OUT_W-1:0];
    end
  end
`else
  assign w_out_val = w_scaled;
`endif

  // Integrators, tick counter, comb pipeline FSM and output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= {DEC_LOG2{1'b0}};
      r_i1      <= {ACC_W{1'b0}};
      r_i2      <= {ACC_W{1'b0}};
      r_i3      <= {ACC_W{1'b0}};
      r_i3_lat  <= {ACC_W{1'b0}};
      r_i3_d    <= {ACC_W{1'b0}};
      r_c1      <= {ACC_W{1'b0}};
      r_c1_d    <= {ACC_W{1'b0}};
      r_c2      <= {ACC_W{1'b0}};
      r_c2_d    <= {ACC_W{1'b0}};
      r_c3      <= {ACC_W{1'b0}};
`ifdef PCM_DC_BLOCK_EN
      r_dc_s    <= {OUT_W{1'b0}};
      r_dc_h    <= {OUT_W{1'b0}};
`endif
      pcm_data  <= {OUT_W{1'b0}};
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (pdm_tick) begin
        r_i1  <= w_i1_nx;
        r_i2  <= w_i2_nx;
        r_i3  <= w_i3_nx;
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_dec_tick) begin
        r_i3_lat <= w_i3_nx;
      end
      if (clr_ovr) begin
        overrun <= 1'b0;
      end
      if (pcm_valid && pcm_ready) begin
        pcm_valid <= 1'b0;
      end
      // Later assignments in the OUT state override the clear/consume defaults above.
      case (r_state)
        S_IDLE: begin
          if (w_dec_tick) begin
            r_state <= S_COMB1;
          end
        end
        S_COMB1: begin
          r_c1    <= r_i3_lat - r_i3_d;
          r_i3_d  <= r_i3_lat;
          r_state <= S_COMB2;
        end
        S_COMB2: begin
          r_c2    <= r_c1 - r_c1_d;
          r_c1_d  <= r_c1;
          r_state <= S_COMB3;
        end
        S_COMB3: begin
          r_c3    <= r_c2 - r_c2_d;
          r_c2_d  <= r_c2;
`ifdef PCM_DC_BLOCK_EN
          r_state <= S_DCB;
`else
          r_state <= S_OUT;
`endif
        end
        S_DCB: begin
`ifdef PCM_DC_BLOCK_EN
          r_dc_s <= w_scaled;
          r_dc_h <= w_dc_sat;
`endif
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (!pcm_valid || pcm_ready) begin
            pcm_data  <= w_out_val;
            pcm_valid <= 1'b1;
          end else begin
            overrun   <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator: steady-state levels, transients, latency, overrun and mid-pipeline reset.
module tb_pdm_cic_decimator;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               pdm_tick = 1'b0;
  logic               micData = 1'b0;
  logic               pcm_ready = 1'b0;
  logic               clr_ovr = 1'b0;
  logic signed [15:0] pcm_data;
  logic               pcm_valid;
  logic               overrun;

  int n_cmp = 0;
  int n_mis = 0;
  int g_ph  = 0;
  int lat   = 99;

  always #5 clk = ~clk;

  pdm_cic_decimator #(.DEC_LOG2(6), .OUT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .pdm_tick (pdm_tick),
    .micData  (micData),
    .pcm_data (pcm_data),
    .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready),
    .overrun  (overrun),
    .clr_ovr  (clr_ovr)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Runs nticks PDM ticks spaced 8 clocks apart; starts and ends at a falling edge.
  // On the final tick, lat records clocks from the tick edge until pcm_valid is seen high.
  task automatic frame(input logic [3:0] pat, input int plen, input int nticks,
                       input int rst_j, input bit clr_out);
    lat = 99;
    for (int t = 0; t < nticks; t++) begin
      pdm_tick = 1'b1;
      micData  = pat[g_ph % plen];
      g_ph++;
      for (int j = 1; j <= 8; j++) begin
        @(negedge clk);
        if (j == 1) pdm_tick = 1'b0;
        if (t == nticks - 1) begin
          if (lat == 99 && pcm_valid === 1'b1) lat = j - 1;
          if (rst_j > 0 && j == rst_j) reset = 1'b0;
          if (rst_j > 0 && j == rst_j + 1) begin
            chk("midrst_data", pcm_data, 0);
            chk("midrst_valid", {31'd0, pcm_valid}, 0);
            chk("midrst_ovr", {31'd0, overrun}, 0);
            reset = 1'b1;
          end
          if (clr_out && j == 4) clr_ovr = 1'b1;
          if (clr_out && j == 5) clr_ovr = 1'b0;
        end
      end
    end
  endtask

  task automatic consume(input string tag);
    pcm_ready = 1'b1;
    @(negedge clk);
    pcm_ready = 1'b0;
    chk(tag, {31'd0, pcm_valid}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", pcm_data, 0);
    chk("rst_valid", {31'd0, pcm_valid}, 0);
    chk("rst_ovr", {31'd0, overrun}, 0);
    reset = 1'b1;
    @(negedge clk);

    // Constant 1: transients 45760>>>3 and 220480>>>3, then saturated full scale.
    frame(4'b0001, 1, 64, 0, 1'b0);
    chk("c1_first", pcm_data, 5720);
    chk("c1_lat1", lat, 4);
    consume("c1_cons1");
    frame(4'b0001, 1, 64, 0, 1'b0);
    chk("c1_second", pcm_data, 27560);
    consume("c1_cons2");
    frame(4'b0001, 1, 64, 0, 1'b0);
    chk("c1_steady", pcm_data, 32767);
    chk("c1_lat3", lat, 4);
    chk("c1_ovr", {31'd0, overrun}, 0);
    consume("c1_cons3");

    // Constant 0 -> negative full scale.
    for (int k = 0; k < 3; k++) begin
      frame(4'b0000, 1, 64, 0, 1'b0);
      if (k < 2) consume("c0_cons");
    end
    chk("c0_steady", pcm_data, -32768);
    consume("c0_cons3");

    // Alternating 1,0 -> zero.
    for (int k = 0; k < 3; k++) begin
      frame(4'b0001, 2, 64, 0, 1'b0);
      if (k < 2) consume("alt_cons");
    end
    chk("alt_steady", pcm_data, 0);
    consume("alt_cons3");

    // 1,1,1,0 -> half scale.
    for (int k = 0; k < 3; k++) begin
      frame(4'b0111, 4, 64, 0, 1'b0);
      if (k < 2) consume("half_cons");
    end
    chk("half_steady", pcm_data, 16384);
    consume("half_cons3");

    // Overrun: hold the sample, drop the next one, then set-wins against clr_ovr.
    frame(4'b0111, 4, 64, 0, 1'b0);
    chk("ovr_hold_valid", {31'd0, pcm_valid}, 1);
    chk("ovr_hold_data", pcm_data, 16384);
    chk("ovr_pre", {31'd0, overrun}, 0);
    frame(4'b0001, 1, 64, 0, 1'b0);
    chk("ovr_kept_data", pcm_data, 16384);
    chk("ovr_kept_valid", {31'd0, pcm_valid}, 1);
    chk("ovr_set", {31'd0, overrun}, 1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("ovr_clr", {31'd0, overrun}, 0);
    frame(4'b0001, 1, 64, 0, 1'b1);
    chk("ovr_set_wins", {31'd0, overrun}, 1);
    chk("ovr_set_wins_data", pcm_data, 16384);

    // Reset during COMB2 discards the sample; the next one needs a full 64 ticks.
    frame(4'b0001, 1, 64, 2, 1'b0);
    frame(4'b0001, 1, 63, 0, 1'b0);
    chk("postrst_no_early", {31'd0, pcm_valid}, 0);
    frame(4'b0001, 1, 1, 0, 1'b0);
    chk("postrst_lat", lat, 4);
    chk("postrst_data", pcm_data, 5720);
    consume("postrst_cons");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
